// File: rtl/twiddle_cmul_w8_if.sv
// Sample/handshake bundle for the W8^k twiddle multiplier: input sample with
// twiddle select and stall enable, output sample with valid and saturation flag.
interface twiddle_cmul_w8_if #(
   parameter int WIDTH = 16
);
   logic             en;
   logic             in_valid;
   logic [1:0]       sel;
   logic [WIDTH-1:0] xr;
   logic [WIDTH-1:0] xi;
   logic             out_valid;
   logic [WIDTH-1:0] yr;
   logic [WIDTH-1:0] yi;
   logic             sat;

   modport master (
      output en, in_valid, sel, xr, xi,
      input  out_valid, yr, yi, sat
   );

   modport slave (
      input  en, in_valid, sel, xr, xi,
      output out_valid, yr, yi, sat
   );
endinterface

// File: rtl/twiddle_cmul_w8.sv
// Three-stage complex multiply by W8^k (k = sel): pre-add, shift-add partial
// sums for the 181/256 constant, then round/shift/saturate into the outputs.
module twiddle_cmul_w8 #(
   parameter int WIDTH = 16,
   parameter int ROUND = 1
) (
   input logic              clk_i,
   input logic              rst_i,
   twiddle_cmul_w8_if.slave bus
);
   localparam int STAGES = 3;
   localparam int PW     = WIDTH + 2;
   localparam int AW     = WIDTH + 10;
   localparam logic signed [AW-1:0] RND_C = AW'((ROUND != 0) ? 128 : 0);
   localparam logic signed [AW-1:0] MAX_V = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] MIN_V = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic [STAGES:1]       vld_pipe_q;
   logic                  byp1_q;
   logic [1:0][PW-1:0]    p_d, p1_q;
   logic [1:0][AW-1:0]    a_d, b_d, a2_q, b2_q;
   logic [1:0][WIDTH-1:0] y_d, y_q;
   logic [1:0]            ovf_d;
   logic                  sat_q;
   logic signed [PW-1:0]  xr_e, xi_e;

   assign xr_e = {{2{bus.xr[WIDTH-1]}}, bus.xr};
   assign xi_e = {{2{bus.xi[WIDTH-1]}}, bus.xi};

   // Index 0 is the real component, 1 the imaginary one.
   always_comb begin
      p_d = '0;
      case (bus.sel)
         2'd0: begin
            p_d[0] = xr_e;
            p_d[1] = xi_e;
         end
         2'd1: begin
            p_d[0] = xr_e + xi_e;
            p_d[1] = xi_e - xr_e;
         end
         2'd2: begin
            p_d[0] = xi_e;
            p_d[1] = -xr_e;
         end
         default: begin
            p_d[0] = xi_e - xr_e;
            p_d[1] = -xr_e - xi_e;
         end
      endcase
   end

   generate
      for (genvar c = 0; c < 2; c++) begin : g_comp
         logic signed [AW-1:0] pe, sum, q;
         assign pe = {{(AW-PW){p1_q[c][PW-1]}}, p1_q[c]};
         // Bypass carries p*256 so the common >>>8 leaves it exact.
         assign a_d[c] = byp1_q ? (pe <<< 8) : (pe <<< 7) + (pe <<< 5);
         assign b_d[c] = byp1_q ? '0 : (pe <<< 4) + (pe <<< 2) + pe;
         assign sum      = $signed(a2_q[c]) + $signed(b2_q[c]) + RND_C;
         assign q        = sum >>> 8;
         assign ovf_d[c] = (q > MAX_V) || (q < MIN_V);
         assign y_d[c]   = (q > MAX_V) ? MAX_V[WIDTH-1:0] :
                           (q < MIN_V) ? MIN_V[WIDTH-1:0] : q[WIDTH-1:0];
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe_q <= '0;
         byp1_q     <= 1'b0;
         p1_q       <= '0;
         a2_q       <= '0;
         b2_q       <= '0;
         y_q        <= '0;
         sat_q      <= 1'b0;
      end else if (bus.en) begin
         vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
         byp1_q     <= ~bus.sel[0];
         p1_q       <= p_d;
         a2_q       <= a_d;
         b2_q       <= b_d;
         y_q        <= y_d;
         sat_q      <= |ovf_d;
      end
   end

   assign bus.out_valid = vld_pipe_q[STAGES];
   assign bus.yr        = y_q[0];
   assign bus.yi        = y_q[1];
   assign bus.sat       = sat_q;
endmodule

// File: tb/tb_twiddle_cmul_w8.sv
// Directed and randomized checks of twiddle_cmul_w8 at WIDTH 16/12, ROUND 1/0,
// against an arithmetic model of the complex twiddle multiply.
module tb_twiddle_cmul_w8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   twiddle_cmul_w8_if #(.WIDTH(16)) i0 ();
   twiddle_cmul_w8_if #(.WIDTH(16)) i1 ();
   twiddle_cmul_w8_if #(.WIDTH(12)) i2 ();
   twiddle_cmul_w8_if #(.WIDTH(12)) i3 ();

   twiddle_cmul_w8 #(.WIDTH(16), .ROUND(1)) u0 (.clk_i(clk), .rst_i(rst), .bus(i0));
   twiddle_cmul_w8 #(.WIDTH(16), .ROUND(0)) u1 (.clk_i(clk), .rst_i(rst), .bus(i1));
   twiddle_cmul_w8 #(.WIDTH(12), .ROUND(1)) u2 (.clk_i(clk), .rst_i(rst), .bus(i2));
   twiddle_cmul_w8 #(.WIDTH(12), .ROUND(0)) u3 (.clk_i(clk), .rst_i(rst), .bus(i3));

   typedef struct {
      longint yr;
      longint yi;
      bit     s;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t exq[4][$];

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Multiply by 181/256 (or pass through), round/floor, then clamp.
   function automatic longint scale(input longint p, input bit byp, input int w,
                                    input bit rnd, output bit ovf);
      longint q, mx, mn;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -(longint'(1) <<< (w - 1));
      q  = byp ? p : ((p * 181 + (rnd ? 128 : 0)) >>> 8);
      ovf = (q > mx) || (q < mn);
      return (q > mx) ? mx : (q < mn) ? mn : q;
   endfunction

   function automatic exp_t model(input int w, input bit rnd, input logic [1:0] k,
                                  input longint xr, input longint xi);
      longint pr, pi;
      bit o1, o2;
      exp_t e;
      case (k)
         2'd0: begin pr = xr;      pi = xi;      end
         2'd1: begin pr = xr + xi; pi = xi - xr; end
         2'd2: begin pr = xi;      pi = -xr;     end
         default: begin pr = xi - xr; pi = -xr - xi; end
      endcase
      e.yr = scale(pr, !k[0], w, rnd, o1);
      e.yi = scale(pi, !k[0], w, rnd, o2);
      e.s  = o1 | o2;
      return e;
   endfunction

   function automatic longint rv(input int w);
      case ($urandom_range(0, 5))
         0: return -(longint'(1) <<< (w - 1));
         1: return (longint'(1) <<< (w - 1)) - 1;
         default: return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) <<< (w - 1));
      endcase
   endfunction

   task automatic drive(input bit en, input bit v, input logic [1:0] k,
                        input longint ar, input longint ai,
                        input longint br, input longint bi);
      logic [63:0] ar_v, ai_v, br_v, bi_v;
      ar_v = ar; ai_v = ai; br_v = br; bi_v = bi;
      i0.en = en; i0.in_valid = v; i0.sel = k; i0.xr = ar_v[15:0]; i0.xi = ai_v[15:0];
      i1.en = en; i1.in_valid = v; i1.sel = k; i1.xr = ar_v[15:0]; i1.xi = ai_v[15:0];
      i2.en = en; i2.in_valid = v; i2.sel = k; i2.xr = br_v[11:0]; i2.xi = bi_v[11:0];
      i3.en = en; i3.in_valid = v; i3.sel = k; i3.xr = br_v[11:0]; i3.xi = bi_v[11:0];
   endtask

   task automatic d16(input bit en, input bit v, input logic [1:0] k,
                      input longint ar, input longint ai);
      drive(en, v, k, ar, ai, ar, ai);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk0(input string tag, input bit ov, input longint yr,
                       input longint yi, input bit s);
      check({tag, "_ov"}, i0.out_valid, ov);
      check({tag, "_yr"}, $signed(i0.yr), yr);
      check({tag, "_yi"}, $signed(i0.yi), yi);
      check({tag, "_sat"}, i0.sat, s);
   endtask

   task automatic chk_model(input string tag, input bit ov, input exp_t e);
      chk0(tag, ov, e.yr, e.yi, e.s);
   endtask

   task automatic cmp_inst(input int idx, input bit ov, input longint yr,
                           input longint yi, input bit s);
      exp_t e;
      if (ov) begin
         check($sformatf("rnd%0d_expected_pending", idx), longint'(exq[idx].size() > 0), 1);
         if (exq[idx].size() > 0) begin
            e = exq[idx].pop_front();
            check($sformatf("rnd%0d_yr", idx), yr, e.yr);
            check($sformatf("rnd%0d_yi", idx), yi, e.yi);
            check($sformatf("rnd%0d_sat", idx), s, e.s);
         end
      end
   endtask

   task automatic cmp_all();
      cmp_inst(0, i0.out_valid, $signed(i0.yr), $signed(i0.yi), i0.sat);
      cmp_inst(1, i1.out_valid, $signed(i1.yr), $signed(i1.yi), i1.sat);
      cmp_inst(2, i2.out_valid, $signed(i2.yr), $signed(i2.yi), i2.sat);
      cmp_inst(3, i3.out_valid, $signed(i3.yr), $signed(i3.yi), i3.sat);
   endtask

   initial begin
      longint snap;
      exp_t   s0, s1, s2, s3;
      bit     en, v;
      logic [1:0] k;
      longint ar, ai, br, bi;

      // Reset: outputs cleared while rst is held
      rst = 1'b1;
      d16(1, 1, 2'd1, 1234, 4321);
      tick();
      chk0("rst1", 0, 0, 0, 0);
      tick();
      chk0("rst2", 0, 0, 0, 0);
      rst = 1'b0;

      // Identity, exact 3-cycle latency
      d16(1, 1, 2'd0, 1000, -2000);
      tick();
      d16(1, 0, 2'd0, 0, 0);
      tick();
      check("id_lat_early", i0.out_valid, 0);
      tick();
      chk0("identity", 1, 1000, -2000, 0);

      // k=2 then k=1 back to back
      d16(1, 1, 2'd2, 1000, -2000);
      tick();
      d16(1, 1, 2'd1, 1000, 0);
      tick();
      d16(1, 0, 2'd0, 0, 0);
      tick();
      chk0("k2", 1, -2000, -1000, 0);
      tick();
      chk0("k1", 1, 707, -707, 0);
      tick();
      check("k1_after_ov", i0.out_valid, 0);

      // Saturation corners
      d16(1, 1, 2'd3, -32768, -32768);
      tick();
      d16(1, 1, 2'd2, -32768, 5);
      tick();
      d16(1, 0, 2'd0, 0, 0);
      tick();
      chk0("sat_k3", 1, 0, 32767, 1);
      tick();
      chk0("sat_k2", 1, 5, 32767, 1);

      // Stall of 5 cycles with in_valid pattern 1,0,1,1
      s0 = model(16, 1, 2'd1, 300, -400);
      s1 = model(16, 1, 2'd3, 1234, 567);
      s2 = model(16, 1, 2'd2, -5, 77);
      s3 = model(16, 1, 2'd0, -32768, 32767);
      d16(1, 1, 2'd1, 300, -400);
      tick();
      d16(1, 0, 2'd3, 1234, 567);
      tick();
      snap = {i0.out_valid, i0.yr, i0.yi, i0.sat};
      d16(0, 1, 2'd3, -32768, -32768);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("stall_frozen%0d", i), {i0.out_valid, i0.yr, i0.yi, i0.sat}, snap);
      end
      d16(1, 1, 2'd2, -5, 77);
      tick();
      chk_model("stall_s0", 1, s0);
      d16(1, 1, 2'd0, -32768, 32767);
      tick();
      chk_model("stall_s1_bubble", 0, s1);
      d16(1, 0, 2'd0, 0, 0);
      tick();
      chk_model("stall_s2", 1, s2);
      tick();
      chk_model("stall_s3", 1, s3);

      // Reset with three valid samples in flight, en low to show rst priority
      d16(1, 1, 2'd1, 111, 222);
      tick();
      d16(1, 1, 2'd2, 333, 444);
      tick();
      d16(1, 1, 2'd3, 555, 666);
      tick();
      d16(0, 1, 2'd0, 777, 888);
      rst = 1'b1;
      tick();
      chk0("midrst", 0, 0, 0, 0);
      rst = 1'b0;
      d16(1, 0, 2'd0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("flushed%0d", i), i0.out_valid, 0);
      end

      // Random regression across all four configurations
      for (int n = 0; n < 10000; n++) begin
         en = ($urandom_range(0, 9) != 0);
         v  = ($urandom_range(0, 3) != 0);
         k  = 2'($urandom_range(0, 3));
         ar = rv(16); ai = rv(16);
         br = rv(12); bi = rv(12);
         drive(en, v, k, ar, ai, br, bi);
         if (en && v) begin
            exq[0].push_back(model(16, 1, k, ar, ai));
            exq[1].push_back(model(16, 0, k, ar, ai));
            exq[2].push_back(model(12, 1, k, br, bi));
            exq[3].push_back(model(12, 0, k, br, bi));
         end
         tick();
         if (en) cmp_all();
      end
      drive(1, 0, 2'd0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         cmp_all();
      end
      for (int i = 0; i < 4; i++)
         check($sformatf("rnd%0d_drained", i), exq[i].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
